// File: rtl/ai_pkg.sv
// Shared types for the SIMD MAC engine: activation modes, FSM states,
// and a lane-packing helper for 8-bit lanes in a 32-bit word.
package ai_pkg;

    typedef enum logic [1:0] {
        AI_ACT_NONE  = 2'b00,
        AI_ACT_RELU  = 2'b01,
        AI_ACT_STEP  = 2'b10,
        AI_ACT_SAT16 = 2'b11
    } ai_act_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ACT,
        S_DONE
    } state_e;

    function automatic logic [31:0] pack4x8(
        input logic [7:0] e3,
        input logic [7:0] e2,
        input logic [7:0] e1,
        input logic [7:0] e0
    );
        return {e3, e2, e1, e0};
    endfunction

endpackage

// File: rtl/ai_simd_mac_engine_if.sv
// Control and operand-stream bundle of the SIMD MAC engine.
// master = pipeline side, slave = engine side.
interface ai_simd_mac_engine_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 5
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [1:0]        mode;
    logic              is_signed;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              overflow;

    modport master (
        output start, len, mode, is_signed,
        output op_valid, op_a, op_b,
        input  op_ready, busy, done, result, overflow
    );

    modport slave (
        input  start, len, mode, is_signed,
        input  op_valid, op_a, op_b,
        output op_ready, busy, done, result, overflow
    );
endinterface

// File: rtl/simd_lane_dot.sv
// Combinational packed-lane dot product: sum over lanes of a[i]*b[i],
// lanes sign- or zero-extended by is_signed.
module simd_lane_dot #(
    parameter int DATA_W = 32,
    parameter int ELEM_W = 8,
    parameter int SUM_W  = 2*ELEM_W + $clog2(DATA_W/ELEM_W) + 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              is_signed,
    output logic [SUM_W-1:0]  sum
);
    localparam int LANES = DATA_W / ELEM_W;
    localparam int PAD   = SUM_W - 2*ELEM_W;

    logic signed [ELEM_W:0]     ea;
    logic signed [ELEM_W:0]     eb;
    logic signed [2*ELEM_W+1:0] prod;

    always_comb begin
        sum  = '0;
        ea   = '0;
        eb   = '0;
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            ea = {is_signed & a[i*ELEM_W+ELEM_W-1],
                  a[i*ELEM_W +: ELEM_W]};
            eb = {is_signed & b[i*ELEM_W+ELEM_W-1],
                  b[i*ELEM_W +: ELEM_W]};
            prod = ea * eb;
            // the low 2*ELEM_W bits hold the exact product either way
            sum = sum + {{PAD{is_signed & prod[2*ELEM_W-1]}},
                         prod[2*ELEM_W-1:0]};
        end
    end
endmodule

// File: rtl/ai_simd_mac_engine.sv
// Multi-cycle packed-SIMD MAC: streams LEN operand pairs into an
// accumulator, then applies a selectable activation to the result.
module ai_simd_mac_engine
    import ai_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ELEM_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MAX_LEN = 16
) (
    input  logic clk,
    input  logic reset,
    ai_simd_mac_engine_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int SUM_W = 2*ELEM_W + $clog2(DATA_W/ELEM_W) + 1;

    localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] SMIN = (ACC_W+1)'(-32768);
    localparam logic signed [ACC_W:0] UMAX = (ACC_W+1)'(65535);

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt;
    ai_act_e           mode_q;
    logic              sgn_q;
    logic [ACC_W-1:0]  acc;
    logic              ovf_q;
    logic [ACC_W-1:0]  result_q;
    logic              done_q;

    logic [SUM_W-1:0]  dot;
    logic [ACC_W-1:0]  dot_sx;
    logic [ACC_W-1:0]  dot_zx;
    logic [ACC_W-1:0]  dot_acc;
    logic [ACC_W:0]    add;
    logic              add_ovf;
    logic signed [ACC_W:0] av;
    logic [ACC_W-1:0]  act_val;
    logic              start_ok;
    logic              beat;
    logic              last_beat;

    simd_lane_dot #(
        .DATA_W (DATA_W),
        .ELEM_W (ELEM_W),
        .SUM_W  (SUM_W)
    ) u_dot (
        .a         (bus.op_a),
        .b         (bus.op_b),
        .is_signed (sgn_q),
        .sum       (dot)
    );

    assign start_ok  = bus.start &&
                       (state == S_IDLE || state == S_DONE);
    assign beat      = bus.op_valid && bus.op_ready;
    assign last_beat = beat && (cnt == len_q - 1'b1);

    assign dot_sx  = ACC_W'($signed(dot));
    assign dot_zx  = ACC_W'(dot);
    assign dot_acc = sgn_q ? dot_sx : dot_zx;
    assign add     = {1'b0, acc} + {1'b0, dot_acc};

    // signed: same-sign operands giving a different-sign sum
    assign add_ovf = sgn_q
        ? (acc[ACC_W-1] == dot_acc[ACC_W-1]) &&
          (add[ACC_W-1] != acc[ACC_W-1])
        : add[ACC_W];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.start)
                    state_nxt = (bus.len == '0) ? S_ACT : S_ACCUM;
                else
                    state_nxt = S_IDLE;
            end
            S_ACCUM: if (last_beat) state_nxt = S_ACT;
            S_ACT:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.op_ready = (state == S_ACCUM);
        bus.busy     = (state == S_ACCUM) || (state == S_ACT);
    end

    always_comb begin
        av      = {sgn_q & acc[ACC_W-1], acc};
        act_val = acc;
        unique case (mode_q)
            AI_ACT_NONE: act_val = acc;
            AI_ACT_RELU:
                act_val = (sgn_q && acc[ACC_W-1]) ? '0 : acc;
            AI_ACT_STEP:
                act_val = ACC_W'(sgn_q ? (!acc[ACC_W-1] && |acc)
                                       : |acc);
            AI_ACT_SAT16: begin
                if (sgn_q) begin
                    if (av > SMAX)      act_val = ACC_W'(SMAX);
                    else if (av < SMIN) act_val = ACC_W'(SMIN);
                end else if (av > UMAX) begin
                    act_val = ACC_W'(UMAX);
                end
            end
            default: act_val = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            cnt      <= '0;
            mode_q   <= AI_ACT_NONE;
            sgn_q    <= 1'b0;
            acc      <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == S_ACT);
            if (start_ok) begin
                len_q  <= (bus.len > CNT_W'(MAX_LEN))
                          ? CNT_W'(MAX_LEN) : bus.len;
                mode_q <= ai_act_e'(bus.mode);
                sgn_q  <= bus.is_signed;
                acc    <= '0;
                ovf_q  <= 1'b0;
                cnt    <= '0;
            end else if (beat) begin
                acc   <= add[ACC_W-1:0];
                ovf_q <= ovf_q | add_ovf;
                cnt   <= cnt + 1'b1;
            end
            if (state == S_ACT) result_q <= act_val;
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
endmodule
